read_returner: RTL and testbench

- Sits directly downstream of the back-end burst handler and consumes its returner interface (valid, type, data, index).
- Read data comes back out of order, per burst and per column. The block parks it in an index-addressed reorder store.
- It releases read data to the front end strictly in index order over a valid/ready handshake.
- Write completions are forwarded immediately as one-cycle acknowledge pulses.

---
 rtl/types_def.sv | 20 ++
 rtl/read_returner_store.sv | 89 ++++++++
 rtl/read_returner.sv | 181 ++++++++++++++++++
 tb/tb_read_returner.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_def.sv
// ---------------------------------------------------------------------------
// types_def
// Shared type and size definitions for the back-end return path.
//   data_width        width of one data beat
//   read_entries_log  log2 of the read index space
//   read_entries      number of read indices (reorder store depth)
//   r_type            returner beat type: read data or write completion
// ---------------------------------------------------------------------------
package types_def;

  localparam int data_width       = 16;
  localparam int read_entries_log = 4;
  localparam int read_entries     = 2 ** read_entries_log;

  typedef enum logic {
    R_READ  = 1'b0,
    R_WRITE = 1'b1
  } r_type;

endpackage

// File: rtl/read_returner_store.sv
// ---------------------------------------------------------------------------
// returner_store
// Index-addressed reorder store for out-of-order read data.
// The data array has no reset and a registered read port, so it maps onto
// block RAM; that read register is the front-end output data register.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset (valid bits, read reg)
//   we            write a beat into slot[wr_index] and mark it valid
//   wr_index      slot written by the burst handler
//   wr_data       beat data
//   head          slot currently at the head of the in-order stream
//   rd_en         load the read register (from slot[head] or bypass data)
//   rd_bypass     with rd_en: load bypass_data instead of slot[head]
//   bypass_data   incoming beat routed straight to the read register
//   rd_data       registered read data
//   valid         per-slot valid vector
// ---------------------------------------------------------------------------
module returner_store #(
  parameter int data_width       = types_def::data_width,
  parameter int read_entries_log = types_def::read_entries_log
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [read_entries_log-1:0]   wr_index,
  input  logic [data_width-1:0]         wr_data,
  input  logic [read_entries_log-1:0]   head,
  input  logic                          rd_en,
  input  logic                          rd_bypass,
  input  logic [data_width-1:0]         bypass_data,
  output logic [data_width-1:0]         rd_data,
  output logic [2**read_entries_log-1:0] valid
);

  import types_def::*;

  localparam int depth = 2 ** read_entries_log;

  logic [data_width-1:0] mem [depth];
  logic [data_width-1:0] rd_data_reg;

  // A slot at head is only emptied when it is read from the store, never
  // when the register is loaded from the bypass path.
  logic clr_head;
  assign clr_head = rd_en && !rd_bypass;

  // Data array: write-only here, read through the registered port below.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_index] <= wr_data;
    end
  end

  // Registered read. Read-before-write: if the head slot is overwritten in
  // the same cycle it is loaded, the old data goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= rd_bypass ? bypass_data : mem[head];
    end
  end

  assign rd_data = rd_data_reg;

  // Per-slot valid bits. A new write wins over a clear of the same slot,
  // so an overwrite that races a load leaves the new data pending.
  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_slot
      localparam logic [read_entries_log-1:0] slot_id = read_entries_log'(gi);
      logic valid_bit_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_bit_reg <= 1'b0;
        end else if (we && (wr_index == slot_id)) begin
          valid_bit_reg <= 1'b1;
        end else if (clr_head && (head == slot_id)) begin
          valid_bit_reg <= 1'b0;
        end
      end

      assign valid[gi] = valid_bit_reg;
    end
  endgenerate

endmodule

// File: rtl/read_returner.sv
// ---------------------------------------------------------------------------
// read_returner
// Consumes the burst handler's returner interface. Read beats arrive out of
// order and are parked in an index-addressed reorder store, then released to
// the front end strictly in index order over valid/ready. Write completions
// are forwarded as one-cycle acknowledge pulses.
//
// Optional feature macro: READ_RETURNER_BYPASS_EN
//   When defined, a read beat for the head index that finds the head slot
//   empty and the output register free is loaded straight into the output
//   register (1-cycle latency) instead of going through the store.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        returner beat valid (always consumed, no backpressure)
//   in_type         R_READ or R_WRITE
//   in_data         read data (ignored for writes)
//   in_index        request index
//   rd_valid        in-order read response valid
//   rd_ready        front end accepts the response
//   rd_data         response data
//   rd_index        response index (head pointer at load time)
//   wr_done_valid   one-cycle write completion pulse
//   wr_done_index   index of the completed write
//   free_count      store slots not holding undelivered data
//   overflow_err    sticky: a read beat hit a slot that was still valid
// ---------------------------------------------------------------------------
module read_returner #(
  parameter int data_width       = types_def::data_width,
  parameter int read_entries_log = types_def::read_entries_log
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  types_def::r_type            in_type,
  input  logic [data_width-1:0]       in_data,
  input  logic [read_entries_log-1:0] in_index,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [data_width-1:0]       rd_data,
  output logic [read_entries_log-1:0] rd_index,
  output logic                        wr_done_valid,
  output logic [read_entries_log-1:0] wr_done_index,
  output logic [read_entries_log:0]   free_count,
  output logic                        overflow_err
);

  import types_def::*;

  localparam int depth = 2 ** read_entries_log;
  localparam logic [read_entries_log:0] full_count = (read_entries_log + 1)'(depth);

  // Registered state
  logic [read_entries_log-1:0] head_reg;
  logic                        rd_valid_reg;
  logic [read_entries_log-1:0] rd_index_reg;
  logic                        wr_done_valid_reg;
  logic [read_entries_log-1:0] wr_done_index_reg;
  logic [read_entries_log:0]   free_count_reg;
  logic                        overflow_reg;

  // Store interface
  logic [depth-1:0]            slot_valid;
  logic [data_width-1:0]       store_rd_data;

  // Per-cycle decisions
  logic rd_beat;
  logic wr_beat;
  logic head_valid;
  logic slot_taken;
  logic out_free;
  logic handshake;
  logic load_store;
  logic bypass;
  logic load;
  logic store_we;
  logic fill;

  always_comb begin
    rd_beat    = in_valid && (in_type == R_READ);
    wr_beat    = in_valid && (in_type == R_WRITE);
    head_valid = slot_valid[head_reg];
    slot_taken = slot_valid[in_index];
    out_free   = !rd_valid_reg || rd_ready;
    handshake  = rd_valid_reg && rd_ready;
    // Decided on the pre-edge valid bits: a beat landing in an empty head
    // slot this cycle is not visible to the load until the next cycle.
    load_store = head_valid && out_free;
`ifdef READ_RETURNER_BYPASS_EN
    bypass     = rd_beat && (in_index == head_reg) && !head_valid && out_free;
`else
    bypass     = 1'b0;
`endif
    load       = load_store || bypass;
    store_we   = rd_beat && !bypass;
    // Only a beat into an empty slot consumes a free slot; an overwrite
    // of a still-valid slot does not.
    fill       = store_we && !slot_taken;
  end

  returner_store #(
    .data_width       (data_width),
    .read_entries_log (read_entries_log)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .we          (store_we),
    .wr_index    (in_index),
    .wr_data     (in_data),
    .head        (head_reg),
    .rd_en       (load),
    .rd_bypass   (bypass),
    .bypass_data (in_data),
    .rd_data     (store_rd_data),
    .valid       (slot_valid)
  );

  // Head pointer and output register control. The data half of the output
  // register lives in the store's read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= '0;
      rd_valid_reg <= 1'b0;
      rd_index_reg <= '0;
    end else begin
      if (load) begin
        rd_valid_reg <= 1'b1;
        rd_index_reg <= head_reg;
        head_reg     <= head_reg + 1'b1;  // natural wrap at 2**read_entries_log
      end else if (handshake) begin
        rd_valid_reg <= 1'b0;
      end
    end
  end

  // Write completion pulse: one cycle after the write beat, store untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_done_valid_reg <= 1'b0;
      wr_done_index_reg <= '0;
    end else begin
      wr_done_valid_reg <= wr_beat;
      if (wr_beat) begin
        wr_done_index_reg <= in_index;
      end
    end
  end

  // Free slot accounting, saturating at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_count_reg <= full_count;
    end else if (handshake && !fill) begin
      if (free_count_reg != full_count) begin
        free_count_reg <= free_count_reg + 1'b1;
      end
    end else if (fill && !handshake) begin
      if (free_count_reg != '0) begin
        free_count_reg <= free_count_reg - 1'b1;
      end
    end
  end

  // Sticky overwrite detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (store_we && slot_taken) begin
      overflow_reg <= 1'b1;
    end
  end

  assign rd_valid      = rd_valid_reg;
  assign rd_data       = store_rd_data;
  assign rd_index      = rd_index_reg;
  assign wr_done_valid = wr_done_valid_reg;
  assign wr_done_index = wr_done_index_reg;
  assign free_count    = free_count_reg;
  assign overflow_err  = overflow_reg;

endmodule

// File: tb/tb_read_returner.sv
// ---------------------------------------------------------------------------
// tb_read_returner
// Self-checking bench for read_returner: directed scenarios plus a random
// phase, all compared against a reference model that tracks pending read
// data per index, the in-order head and the delivered response.
// ---------------------------------------------------------------------------
module tb_read_returner;

  import types_def::*;

  localparam int DW  = types_def::data_width;
  localparam int LOG = types_def::read_entries_log;
  localparam int N   = types_def::read_entries;

`ifdef READ_RETURNER_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  r_type          in_type;
  logic [DW-1:0]  in_data;
  logic [LOG-1:0] in_index;
  logic           rd_valid;
  logic           rd_ready;
  logic [DW-1:0]  rd_data;
  logic [LOG-1:0] rd_index;
  logic           wr_done_valid;
  logic [LOG-1:0] wr_done_index;
  logic [LOG:0]   free_count;
  logic           overflow_err;

  read_returner dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_type       (in_type),
    .in_data       (in_data),
    .in_index      (in_index),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_index      (rd_index),
    .wr_done_valid (wr_done_valid),
    .wr_done_index (wr_done_index),
    .free_count    (free_count),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  int total_count = 0;
  int bad_count   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_count++;
    if (got !== exp) begin
      bad_count++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_slot [int];   // pending read data keyed by index
  int            m_head;
  bit            m_outv;
  logic [DW-1:0] m_outd;
  int            m_outi;
  bit            m_wrv;
  int            m_wri;
  int            m_free;
  bit            m_ovf;

  function automatic void model_reset();
    m_slot.delete();
    m_head = 0; m_outv = 0; m_outd = '0; m_outi = 0;
    m_wrv = 0; m_wri = 0; m_free = N; m_ovf = 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  function automatic void model_step();
    bit rdb, was, ofree, hs, byp, fill;
    int idx;
    rdb   = in_valid && (in_type == R_READ);
    idx   = int'(in_index);
    was   = m_slot.exists(idx);
    ofree = !m_outv || rd_ready;
    hs    = m_outv && rd_ready;
    byp   = 0;
`ifdef READ_RETURNER_BYPASS_EN
    byp   = rdb && (idx == m_head) && !m_slot.exists(m_head) && ofree;
`endif
    fill  = rdb && !byp && !was;
    m_wrv = in_valid && (in_type == R_WRITE);
    if (m_wrv) m_wri = idx;
    if (m_slot.exists(m_head) && ofree) begin
      m_outd = m_slot[m_head];
      m_slot.delete(m_head);
      m_outi = m_head;
      m_outv = 1;
      m_head = (m_head + 1) % N;
    end else if (byp) begin
      m_outd = in_data;
      m_outi = m_head;
      m_outv = 1;
      m_head = (m_head + 1) % N;
    end else if (hs) begin
      m_outv = 0;
    end
    if (rdb && !byp) begin
      if (was) m_ovf = 1;
      m_slot[idx] = in_data;
    end
    if (hs && !fill) m_free = (m_free < N) ? m_free + 1 : N;
    else if (fill && !hs) m_free = (m_free > 0) ? m_free - 1 : 0;
  endfunction

  task automatic compare_all();
    check_val("rd_valid", 64'(rd_valid), 64'(m_outv));
    if (m_outv) begin
      check_val("rd_data", 64'(rd_data), 64'(m_outd));
      check_val("rd_index", 64'(rd_index), 64'(m_outi));
    end
    check_val("wr_done_valid", 64'(wr_done_valid), 64'(m_wrv));
    if (m_wrv) check_val("wr_done_index", 64'(wr_done_index), 64'(m_wri));
    check_val("free_count", 64'(free_count), 64'(m_free));
    check_val("overflow_err", 64'(overflow_err), 64'(m_ovf));
  endtask

  // ---------------- stimulus helpers ----------------
  int            cyc = 0;
  int            got_idx [$];
  logic [DW-1:0] got_dat [$];
  int            got_cyc [$];

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    if (rd_valid && rd_ready) begin
      got_idx.push_back(int'(rd_index));
      got_dat.push_back(rd_data);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic send_read(input int idx, input logic [DW-1:0] dat);
    in_valid = 1'b1; in_type = R_READ; in_index = LOG'(idx); in_data = dat;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    got_idx.delete(); got_dat.delete(); got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    compare_all();
    clear_log();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_type = R_READ; in_data = '0; in_index = '0; rd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    // Reset state
    check_val("reset rd_valid", 64'(rd_valid), 64'd0);
    check_val("reset rd_data", 64'(rd_data), 64'd0);
    check_val("reset rd_index", 64'(rd_index), 64'd0);
    check_val("reset wr_done", 64'(wr_done_valid), 64'd0);
    check_val("reset wr_done_index", 64'(wr_done_index), 64'd0);
    check_val("reset free_count", 64'(free_count), 64'(N));
    check_val("reset overflow", 64'(overflow_err), 64'd0);

    // 1. In-order single read and its latency
    do_reset();
    rd_ready = 1'b1;
    in_valid = 1'b1; in_type = R_READ; in_index = '0; in_data = 16'hA5A5;
    cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!rd_valid && lat < 10) begin
      cycle();
      lat++;
    end
    check_val("single latency", 64'(lat), 64'(EXP_LAT));
    check_val("single rd_data", 64'(rd_data), 64'hA5A5);
    check_val("single rd_index", 64'(rd_index), 64'd0);
    repeat (2) cycle();
    check_val("single free_count", 64'(free_count), 64'(N));

    // 2. Out-of-order fill
    do_reset();
    rd_ready = 1'b1;
    send_read(3, 16'd30);
    send_read(1, 16'd10);
    send_read(2, 16'd20);
    check_val("ooo hold rd_valid", 64'(rd_valid), 64'd0);
    send_read(0, 16'd0);
    repeat (6) cycle();
    check_val("ooo count", 64'(got_idx.size()), 64'd4);
    for (int k = 0; k < 4 && k < got_idx.size(); k++) begin
      check_val("ooo index", 64'(got_idx[k]), 64'(k));
      check_val("ooo data", 64'(got_dat[k]), 64'(k * 10));
      check_val("ooo consecutive", 64'(got_cyc[k] - got_cyc[0]), 64'(k));
    end

    // 3. Backpressure
    do_reset();
    rd_ready = 1'b0;
    send_read(0, 16'h1111);
    send_read(1, 16'h2222);
    repeat (2) cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_val("bp rd_valid", 64'(rd_valid), 64'd1);
      check_val("bp rd_data", 64'(rd_data), 64'h1111);
      check_val("bp rd_index", 64'(rd_index), 64'd0);
    end
    rd_ready = 1'b1;
    cycle();
    check_val("bp next rd_valid", 64'(rd_valid), 64'd1);
    check_val("bp next rd_data", 64'(rd_data), 64'h2222);
    check_val("bp next rd_index", 64'(rd_index), 64'd1);
    repeat (2) cycle();

    // 4. Write acknowledge
    do_reset();
    rd_ready = 1'b1;
    in_valid = 1'b1; in_type = R_WRITE; in_index = LOG'(7); in_data = DW'($urandom);
    cycle();
    in_valid = 1'b0;
    check_val("wack valid", 64'(wr_done_valid), 64'd1);
    check_val("wack index", 64'(wr_done_index), 64'd7);
    check_val("wack free_count", 64'(free_count), 64'(N));
    cycle();
    check_val("wack pulse end", 64'(wr_done_valid), 64'd0);
    repeat (3) cycle();
    check_val("wack no read", 64'(rd_valid), 64'd0);

    // 5a. Overflow: two reads to index 5 without drain
    do_reset();
    rd_ready = 1'b1;
    send_read(5, 16'h0055);
    send_read(5, 16'h0066);
    check_val("ovf flag", 64'(overflow_err), 64'd1);
    check_val("ovf free_count", 64'(free_count), 64'(N - 1));
    for (int k = 0; k < 5; k++) send_read(k, DW'(k));
    repeat (6) cycle();
    check_val("ovf count", 64'(got_idx.size()), 64'd6);
    if (got_idx.size() == 6) begin
      check_val("ovf last index", 64'(got_idx[5]), 64'd5);
      check_val("ovf last data", 64'(got_dat[5]), 64'h0066);
    end
    check_val("ovf sticky", 64'(overflow_err), 64'd1);

    // 5b. Head wrap
    do_reset();
    rd_ready = 1'b1;
    for (int k = 0; k < N + 2; k++) send_read(k % N, DW'(k * 3 + 1));
    repeat (4) cycle();
    check_val("wrap count", 64'(got_idx.size()), 64'(N + 2));
    for (int k = 0; k < N + 2 && k < got_idx.size(); k++) begin
      check_val("wrap index", 64'(got_idx[k]), 64'(k % N));
      check_val("wrap data", 64'(got_dat[k]), 64'(k * 3 + 1));
    end

    // Random phase
    do_reset();
    for (int t = 0; t < 800; t++) begin
      int act, idx;
      rd_ready = ($urandom_range(0, 3) != 0);
      act = $urandom_range(0, 9);
      in_valid = 1'b0;
      if (act < 2) begin
        in_valid = 1'b1; in_type = R_WRITE;
        in_index = LOG'($urandom_range(0, N - 1)); in_data = DW'($urandom);
      end else if (act < 8) begin
        idx = ($urandom_range(0, 2) == 0) ? m_head : $urandom_range(0, N - 1);
        if (!m_slot.exists(idx)) begin
          in_valid = 1'b1; in_type = R_READ;
          in_index = LOG'(idx); in_data = DW'($urandom);
        end
      end
      cycle();
    end
    in_valid = 1'b0;

    // 6. Asynchronous reset mid-stream
    do_reset();
    rd_ready = 1'b0;
    send_read(0, 16'h0A00);
    send_read(1, 16'h0A01);
    send_read(2, 16'h0A02);
    send_read(3, 16'h0A03);
    cycle();
    check_val("pre-rst rd_valid", 64'(rd_valid), 64'd1);
    check_val("pre-rst free_count", 64'(free_count), 64'(N - 4));
    #2 rst = 1'b1;
    #1;
    check_val("arst rd_valid", 64'(rd_valid), 64'd0);
    check_val("arst rd_data", 64'(rd_data), 64'd0);
    check_val("arst rd_index", 64'(rd_index), 64'd0);
    check_val("arst free_count", 64'(free_count), 64'(N));
    check_val("arst overflow", 64'(overflow_err), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    clear_log();
    rd_ready = 1'b1;
    send_read(0, 16'hBEEF);
    repeat (4) cycle();
    check_val("post-rst count", 64'(got_idx.size()), 64'd1);
    if (got_idx.size() == 1) begin
      check_val("post-rst index", 64'(got_idx[0]), 64'd0);
      check_val("post-rst data", 64'(got_dat[0]), 64'hBEEF);
    end

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
